// File: rtl/clkrec_pkg.sv
// Shared constants and width helpers for the clock-recovery front end.
package clkrec_pkg;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  // Bits needed to index n items; never less than one.
  function automatic int clog2_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clkrec_decim.sv
// Max/average decimator: one output sample per DECIM accepted input samples.
module clkrec_decim
  import clkrec_pkg::*;
#(
  parameter int DW    = 12,
  parameter int DECIM = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] din,
  input  logic                 mode,
  output logic                 dec_valid,
  output logic signed [DW-1:0] dec_data
);

  localparam int LW = clog2_w(DECIM);
  localparam int AW = DW + LW;
  localparam logic [LW-1:0] LAST = LW'(DECIM - 1);

  logic [LW-1:0]        cnt_r;
  logic                 mode_r;
  logic signed [AW-1:0] acc_r;
  logic                 dec_valid_r;
  logic signed [DW-1:0] dec_data_r;

  logic                 first_s;
  logic                 last_s;
  logic                 mode_s;
  logic signed [AW-1:0] din_ext_s;
  logic signed [AW-1:0] acc_nxt_s;
  logic signed [AW-1:0] avg_s;

  // Next accumulator value; the first sample of a window seeds it and picks the mode.
  always_comb begin
    first_s   = (cnt_r == {LW{1'b0}});
    last_s    = (cnt_r == LAST);
    din_ext_s = {{LW{din[DW-1]}}, din};
    mode_s    = first_s ? mode : mode_r;
    if (first_s) begin
      acc_nxt_s = din_ext_s;
    end else if (mode_s == MODE_AVG) begin
      acc_nxt_s = acc_r + din_ext_s;
    end else if (din_ext_s > acc_r) begin
      acc_nxt_s = din_ext_s;
    end else begin
      acc_nxt_s = acc_r;
    end
    avg_s = acc_nxt_s >>> LW;
  end

  // Window state and registered decimated output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r       <= {LW{1'b0}};
      mode_r      <= MODE_MAX;
      acc_r       <= {AW{1'b0}};
      dec_valid_r <= 1'b0;
      dec_data_r  <= {DW{1'b0}};
    end else if (in_valid) begin
      acc_r <= acc_nxt_s;
      if (first_s) begin
        mode_r <= mode;
      end
      if (last_s) begin
        cnt_r       <= {LW{1'b0}};
        dec_valid_r <= 1'b1;
        dec_data_r  <= (mode_s == MODE_AVG) ? avg_s[DW-1:0] : acc_nxt_s[DW-1:0];
      end else begin
        cnt_r       <= cnt_r + LW'(1'b1);
        dec_valid_r <= 1'b0;
      end
    end else begin
      dec_valid_r <= 1'b0;
    end
  end

  assign dec_valid = dec_valid_r;
  assign dec_data  = dec_data_r;

endmodule

// File: rtl/clkrec_core.sv
// Clock recovery: decimate, slice with hysteresis, debounce, and measure the
// recovered period in decimated samples.
module clkrec_core
  import clkrec_pkg::*;
#(
  parameter int DW    = 12,
  parameter int DECIM = 4,
  parameter int HOLD  = 2,
  parameter int PW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] din,
  input  logic                 mode,
  input  logic signed [DW-1:0] thr_hi,
  input  logic signed [DW-1:0] thr_lo,
  output logic                 dec_valid,
  output logic signed [DW-1:0] dec_data,
  output logic                 out,
  output logic                 out_rise,
  output logic [PW-1:0]        period,
  output logic                 period_valid
);

  localparam int HW = clog2_w(HOLD + 1);
  localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD - 1);
  localparam logic [PW-1:0] PER_MAX = {PW{1'b1}};

  logic                 dec_valid_s;
  logic signed [DW-1:0] dec_data_s;
  logic                 raw_r;
  logic                 raw_s;
  logic [HW-1:0]        deb_r;
  logic                 out_r;
  logic                 out_rise_r;
  logic                 armed_r;
  logic [PW-1:0]        per_cnt_r;
  logic [PW-1:0]        per_inc_s;
  logic [PW-1:0]        period_r;
  logic                 period_valid_r;
  logic                 toggle_s;
  logic                 rise_s;

  clkrec_decim #(
    .DW    (DW),
    .DECIM (DECIM)
  ) u_decim (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .din       (din),
    .mode      (mode),
    .dec_valid (dec_valid_s),
    .dec_data  (dec_data_s)
  );

  // Hysteresis slicer, debounce decision and saturating period increment.
  always_comb begin
    if (dec_valid_s) begin
      if (dec_data_s > thr_hi) begin
        raw_s = 1'b1;
      end else if (dec_data_s < thr_lo) begin
        raw_s = 1'b0;
      end else begin
        raw_s = raw_r;
      end
    end else begin
      raw_s = raw_r;
    end
    toggle_s  = dec_valid_s && (raw_s != out_r) && (deb_r == HOLD_M1);
    rise_s    = toggle_s && !out_r;
    per_inc_s = (per_cnt_r == PER_MAX) ? per_cnt_r : per_cnt_r + PW'(1'b1);
  end

  // Debounced output, edge strobe and period capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_r          <= 1'b0;
      deb_r          <= {HW{1'b0}};
      out_r          <= 1'b0;
      out_rise_r     <= 1'b0;
      armed_r        <= 1'b0;
      per_cnt_r      <= {PW{1'b0}};
      period_r       <= {PW{1'b0}};
      period_valid_r <= 1'b0;
    end else begin
      out_rise_r     <= rise_s;
      period_valid_r <= rise_s && armed_r;
      if (dec_valid_s) begin
        raw_r <= raw_s;
        if (raw_s == out_r) begin
          deb_r <= {HW{1'b0}};
        end else if (toggle_s) begin
          deb_r <= {HW{1'b0}};
          out_r <= ~out_r;
        end else begin
          deb_r <= deb_r + HW'(1'b1);
        end
        // The first rise after reset only arms the measurement.
        if (rise_s) begin
          per_cnt_r <= {PW{1'b0}};
          armed_r   <= 1'b1;
          if (armed_r) begin
            period_r <= per_inc_s;
          end
        end else begin
          per_cnt_r <= per_inc_s;
        end
      end
    end
  end

  assign dec_valid    = dec_valid_s;
  assign dec_data     = dec_data_s;
  assign out          = out_r;
  assign out_rise     = out_rise_r;
  assign period       = period_r;
  assign period_valid = period_valid_r;

endmodule

// File: doc/clkrec_core.md
Name: clkrec_core

Overview:
- Parametrised single-clock clock-recovery front end: decimates a signed ADC stream, slices it with programmable hysteresis, and debounces the result into a recovered square wave.
- Measures the recovered period in decimated samples.
- Successor to the fixed max-downsample plus noise-reduction chain. Adds runtime max/average decimation mode, runtime thresholds, configurable debounce depth, rising-edge strobe and period measurement.
- Sits directly behind the ADC capture, or behind the CDC FIFO on its read clock.

Parameters:
- DW, 12, input/decimated sample width (signed).
- DECIM, 4, input samples per decimated sample; power of two, at least 2.
- HOLD, 2, consecutive disagreeing decimated samples needed to change out; at least 1.
- PW, 16, period counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  din qualifier.
- din  in  DW  signed input sample.
- mode  in  1  0 = max decimation, 1 = average decimation.
- thr_hi  in  DW  signed upper slicing threshold.
- thr_lo  in  DW  signed lower slicing threshold.
- dec_valid  out  1  one-cycle strobe, dec_data new.
- dec_data  out  DW  signed decimated sample.
- out  out  1  recovered, debounced clock.
- out_rise  out  1  one-cycle pulse on each 0->1 of out.
- period  out  PW  decimated samples between the last two rising edges.
- period_valid  out  1  one-cycle strobe, period updated.

Behaviour:
- Reset: all outputs, window counter, accumulator, debounce counter and period counter go to 0 immediately. Reset mid-window discards the partial window; the first accepted sample after release starts a new window.
- Window counter: counts accepted samples (in_valid=1) from 0 to DECIM-1. Cycles with in_valid=0 are ignored; no state changes.
- mode is latched on the first sample of each window. A change mid-window takes effect from the next window.
- Max mode: signed maximum of the DECIM samples.
- Average mode: signed sum in DW+log2(DECIM) bits, then arithmetic shift right by log2(DECIM) (floor). The result always fits in DW bits.
- Decimator latency: dec_valid=1 and dec_data valid in the cycle after the DECIM-th sample is accepted.
- dec_data holds its value between strobes.
- Slicer, evaluated only when dec_valid=1:
  - raw=1 if dec_data > thr_hi.
  - else raw=0 if dec_data < thr_lo.
  - else raw = previous raw.
  - If thr_hi < thr_lo, the thr_hi test has priority.
  - raw resets to 0.
- Debounce counter, advanced on each dec_valid:
  - raw==out: counter cleared.
  - raw!=out: counter increments. When it reaches HOLD, out toggles and the counter clears.
- out changes in the cycle after the qualifying dec_valid: 2 cycles after the final input sample.
- HOLD=1 means out follows raw with that latency.
- out_rise is high in the same cycle out goes 0->1. There is no pulse on 1->0.
- Period counter:
  - Increments, saturating at 2^PW-1, on each dec_valid.
  - On out_rise: period <= counter value including the current dec_valid; counter reloads to 0; period_valid pulses with out_rise.
  - The first rising edge after reset arms the measurement only: counter reloads, no period_valid, period stays 0.
  - A saturated count reports all-ones.
- Simultaneous events: the out_rise reload takes priority over the increment; the increment of that dec_valid is included in the captured value.

Decomposition:
- Package clkrec_pkg:
  - MODE_MAX=1'b0 and MODE_AVG=1'b1 localparams.
  - clog2-based width function for accumulator and window counter.
- Sub-module clkrec_decim holds window counter, mode latch, max/accumulate datapath and dec_valid generation.
- Slicer, debounce and period logic stay in clkrec_core.

Test Plan (DW=12, DECIM=4, HOLD=2, PW=16):
- Max mode, din 5,-3,100,7 contiguous -> dec_data=100, dec_valid single pulse 1 cycle after the sample 7.
- Average mode, 4,8,12,16 -> dec_data=10. Then -1,-2,-2,-3 -> dec_data=-2. Toggling mode after the 2nd sample of a window -> that window still uses the old mode.
- in_valid low for 3 cycles between each sample of 20,30,40,50 (max) -> dec_data=50, one dec_valid, after the 4th accepted sample.
- thr_hi=200, thr_lo=-200, decimated values:
  - 300,300 -> out rises 1 cycle after the 2nd strobe, with out_rise.
  - 0 -> hold.
  - -300,300 -> no change (glitch rejected).
  - -300,-300 -> out falls, no out_rise.
- Steady decimated square wave, 8 at +500 then 8 at -500, repeated:
  - First rise -> no period_valid.
  - Every later rise -> period=16 with period_valid.
- Assert rst low after 2 samples of a window and after out=1 -> all outputs 0 immediately. After release, 4 fresh samples are needed for dec_valid, and the first subsequent rise does not produce period_valid.
